uc_sequencer: RTL and testbench
===============================

UC_SEQUENCER -- requirements
Module: uc_sequencer

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, microcode address width; it SHALL match the microcode ROM address width.
REQ-002 The block SHALL have parameter DEPTH, default 4, number of call-stack entries (power of two, 2..8).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port seq_op, input, 3 bits: sequencing opcode of the current microword.
REQ-006 The block SHALL have port cond_sel, input, 3 bits: index into cond_flags.
REQ-007 The block SHALL have port target, input, ADDR_W bits: branch/call target from the current microword.
REQ-008 The block SHALL have port cond_flags, input, 8 bits: status conditions, cond = cond_flags[cond_sel].
REQ-009 The block SHALL have port disp_addr, input, ADDR_W bits: opcode-dispatch entry address from the instruction decoder.
REQ-010 The block SHALL have port stall, input, 1 bit: hold the sequencer this cycle.
REQ-011 The block SHALL have port uaddr, output, ADDR_W bits: combinational next address, driven straight to the ROM address input.
REQ-012 The block SHALL have port upc, output, ADDR_W bits: registered address of the microword currently on the ROM output.
REQ-013 The block SHALL have port sp, output, clog2(DEPTH)+1 bits: number of occupied stack entries.
REQ-014 The block SHALL have port stk_err, output, 1 bit: sticky stack overflow/underflow flag.
REQ-015 The block SHALL have port waiting, output, 1 bit: high while a WAIT op is holding.

Function
REQ-016 The ROM registers its output 1 cycle after address; the sequencer SHALL load upc <= uaddr on every edge so upc always names the microword currently presented (zero-bubble sequencing).
REQ-017 When stall=1 (rst_n=1), uaddr SHALL equal upc, and upc, stack, sp and stk_err SHALL hold.
REQ-018 When stall=0, uaddr SHALL be decoded from seq_op as follows: 0 NEXT: upc+1.
REQ-019 1 JMP: uaddr SHALL be target.
REQ-020 2 JCC: uaddr SHALL be target if cond=1, else upc+1.
REQ-021 3 JNC: uaddr SHALL be target if cond=0, else upc+1.
REQ-022 4 CALL: uaddr SHALL be target, and upc+1 SHALL be pushed.
REQ-023 5 RET: uaddr SHALL be the top-of-stack value, which is popped.
REQ-024 6 DISP: uaddr SHALL be disp_addr.
REQ-025 7 WAIT: uaddr SHALL be upc while cond=0 (waiting=1), and upc+1 once cond=1.
REQ-026 waiting SHALL be combinational: seq_op==7 and cond==0 and rst_n=1.
REQ-027 upc+1 SHALL be computed modulo 2^ADDR_W (all-ones wraps to 0).
REQ-028 CALL with sp==DEPTH (overflow): the jump SHALL be taken, the push discarded, sp unchanged, and stk_err set.
REQ-029 RET with sp==0 (underflow): uaddr SHALL be 0, sp SHALL stay 0, and stk_err SHALL be set.
REQ-030 stk_err SHALL be sticky and clear only on reset.
REQ-031 Only one stack operation per cycle; the stack SHALL be a LIFO, and a CALL immediately after a RET SHALL reuse the freed slot.
REQ-032 The stack SHALL be implemented as registers (no RAM inference), with DEPTH entries of ADDR_W bits.

Reset
REQ-033 While rst_n=0, uaddr SHALL be 0 combinationally (regardless of stall/seq_op) so the ROM loads word 0 on the reset edge.
REQ-034 On a rising edge with rst_n=0: upc<=0, sp<=0, stk_err<=0; stack contents are don't-care.
REQ-035 Reset SHALL override stall and any in-progress WAIT, CALL or RET.
REQ-036 First cycle after rst_n rises: upc=0, sp=0, stk_err=0, waiting reflects microword 0.

Verification
REQ-037 Reset then NEXT x3: after reset deassert upc 0,1,2,3 on consecutive cycles, and uaddr always equals upc+1.
REQ-038 upc=0x10, JCC target=0x40 cond_sel=2, cond_flags=0x04 -> next upc=0x40; cond_flags=0x00 -> next upc=0x11.
REQ-039 CALL 0x80 at upc=0x20, then CALL 0x90 at upc=0x80, then RET, RET -> upc sequence 0x80, 0x90, 0x81, 0x21, with sp 1, 2, 1, 0 and stk_err=0.
REQ-040 DEPTH=4: five nested CALLs -> fifth jump taken, sp stays 4, stk_err=1; subsequent RET from sp=0 -> uaddr=0, stk_err stays 1.
REQ-041 WAIT at upc=0x30 with cond low 3 cycles, then stall=1 for 2 cycles, then cond high -> waiting high, upc fixed at 0x30 throughout, then upc=0x31 on the first edge with cond=1 and stall=0.
REQ-042 upc=0xFF with NEXT -> upc=0x00; rst_n low mid-WAIT with stall=1 -> uaddr=0 same cycle, upc=0 next edge.

Source files
------------

// File: rtl/uc_sequencer.sv
// Microcode sequencer: picks the next ROM address and keeps a small
// register-based call stack for microcode subroutines.
module uc_sequencer #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [2:0]                 seq_op,
  input  logic [2:0]                 cond_sel,
  input  logic [ADDR_W-1:0]          target,
  input  logic [7:0]                 cond_flags,
  input  logic [ADDR_W-1:0]          disp_addr,
  input  logic                       stall,
  output logic [ADDR_W-1:0]          uaddr,
  output logic [ADDR_W-1:0]          upc,
  output logic [$clog2(DEPTH):0]     sp,
  output logic                       stk_err,
  output logic                       waiting
);

  localparam int IW  = $clog2(DEPTH);
  localparam int SPW = IW + 1;

  localparam logic [2:0] OP_NEXT = 3'd0;
  localparam logic [2:0] OP_JMP  = 3'd1;
  localparam logic [2:0] OP_JCC  = 3'd2;
  localparam logic [2:0] OP_JNC  = 3'd3;
  localparam logic [2:0] OP_CALL = 3'd4;
  localparam logic [2:0] OP_RET  = 3'd5;
  localparam logic [2:0] OP_DISP = 3'd6;
  localparam logic [2:0] OP_WAIT = 3'd7;

  logic [ADDR_W-1:0] upc_q;
  logic [SPW-1:0]    sp_q, sp_d;
  logic              stk_err_q, stk_err_d;
  logic [ADDR_W-1:0] stack_q [DEPTH];

  logic              cond;
  logic [ADDR_W-1:0] upc_inc;
  logic [SPW-1:0]    sp_dec;
  logic              push;
  logic [ADDR_W-1:0] uaddr_d;

  assign cond    = cond_flags[cond_sel];
  assign upc_inc = upc_q + ADDR_W'(1);
  assign sp_dec  = sp_q - SPW'(1);

  // Next-address decode; the stack pointer and error flag move with it.
  always_comb begin
    uaddr_d   = upc_inc;
    sp_d      = sp_q;
    stk_err_d = stk_err_q;
    push      = 1'b0;
    if (!rst_n) begin
      uaddr_d = '0;
    end else if (stall) begin
      uaddr_d = upc_q;
    end else begin
      case (seq_op)
        OP_NEXT: uaddr_d = upc_inc;
        OP_JMP:  uaddr_d = target;
        OP_JCC:  uaddr_d = cond ? target : upc_inc;
        OP_JNC:  uaddr_d = cond ? upc_inc : target;
        OP_CALL: begin
          uaddr_d = target;
          if (sp_q == SPW'(DEPTH)) begin
            stk_err_d = 1'b1;
          end else begin
            push = 1'b1;
            sp_d = sp_q + SPW'(1);
          end
        end
        OP_RET: begin
          if (sp_q == '0) begin
            uaddr_d   = '0;
            stk_err_d = 1'b1;
          end else begin
            uaddr_d = stack_q[sp_dec[IW-1:0]];
            sp_d    = sp_dec;
          end
        end
        OP_DISP: uaddr_d = disp_addr;
        OP_WAIT: uaddr_d = cond ? upc_inc : upc_q;
        default: uaddr_d = upc_inc;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      upc_q     <= '0;
      sp_q      <= '0;
      stk_err_q <= 1'b0;
    end else begin
      upc_q     <= uaddr_d;
      sp_q      <= sp_d;
      stk_err_q <= stk_err_d;
    end
  end

  // Stack contents need no reset; only sp says which entries are live.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      stack_q[sp_q[IW-1:0]] <= upc_inc;
    end
  end

  always_comb begin
    uaddr   = uaddr_d;
    upc     = upc_q;
    sp      = sp_q;
    stk_err = stk_err_q;
    waiting = rst_n && (seq_op == OP_WAIT) && !cond;
  end

endmodule

// File: tb/tb_uc_sequencer.sv
// Directed bench for uc_sequencer: branches, call/return, stack limits,
// WAIT with stall, address wrap and reset in the middle of a WAIT.
module tb_uc_sequencer;

  logic       clk;
  logic       rst_n;
  logic [2:0] seq_op;
  logic [2:0] cond_sel;
  logic [7:0] target;
  logic [7:0] cond_flags;
  logic [7:0] disp_addr;
  logic       stall;
  logic [7:0] uaddr;
  logic [7:0] upc;
  logic [2:0] sp;
  logic       stk_err;
  logic       waiting;

  int checks;
  int errors;

  uc_sequencer #(.ADDR_W(8), .DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seq_op    (seq_op),
    .cond_sel  (cond_sel),
    .target    (target),
    .cond_flags(cond_flags),
    .disp_addr (disp_addr),
    .stall     (stall),
    .uaddr     (uaddr),
    .upc       (upc),
    .sp        (sp),
    .stk_err   (stk_err),
    .waiting   (waiting)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one microword's inputs; settle combinational outputs before checking.
  task automatic drive(input logic [2:0] op, input logic [7:0] tgt,
                       input logic [2:0] csel, input logic [7:0] flags,
                       input logic stl);
    seq_op     = op;
    target     = tgt;
    cond_sel   = csel;
    cond_flags = flags;
    stall      = stl;
    #1;
  endtask

  // Advance one rising edge, then sample away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    disp_addr = 8'hA5;
    drive(3'd7, 8'h33, 3'd0, 8'h00, 1'b1);
    chk("rst_uaddr", uaddr, 8'h00);
    chk("rst_waiting", waiting, 1'b0);
    tick();
    tick();
    chk("rst_upc", upc, 8'h00);
    chk("rst_sp", sp, 3'd0);
    chk("rst_err", stk_err, 1'b0);

    // NEXT run from address 0
    rst_n = 1'b1;
    drive(3'd0, 8'h00, 3'd0, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("next_upc", upc, i);
      chk("next_uaddr", uaddr, i + 1);
      tick();
    end

    // JCC taken / not taken
    drive(3'd1, 8'h10, 3'd0, 8'h00, 1'b0);
    tick();
    chk("jmp_upc", upc, 8'h10);
    drive(3'd2, 8'h40, 3'd2, 8'h04, 1'b0);
    chk("jcc_t_uaddr", uaddr, 8'h40);
    tick();
    chk("jcc_t_upc", upc, 8'h40);
    drive(3'd1, 8'h10, 3'd0, 8'h00, 1'b0);
    tick();
    drive(3'd2, 8'h40, 3'd2, 8'h00, 1'b0);
    tick();
    chk("jcc_nt_upc", upc, 8'h11);

    // JNC and DISP, combinational only
    drive(3'd3, 8'h55, 3'd2, 8'h00, 1'b0);
    chk("jnc_t_uaddr", uaddr, 8'h55);
    drive(3'd3, 8'h55, 3'd2, 8'h04, 1'b0);
    chk("jnc_nt_uaddr", uaddr, 8'h12);
    drive(3'd6, 8'h55, 3'd0, 8'h00, 1'b0);
    chk("disp_uaddr", uaddr, 8'hA5);

    // Nested CALL/RET
    drive(3'd1, 8'h20, 3'd0, 8'h00, 1'b0);
    tick();
    drive(3'd4, 8'h80, 3'd0, 8'h00, 1'b0);
    tick();
    chk("call1_upc", upc, 8'h80);
    chk("call1_sp", sp, 3'd1);
    drive(3'd4, 8'h90, 3'd0, 8'h00, 1'b0);
    tick();
    chk("call2_upc", upc, 8'h90);
    chk("call2_sp", sp, 3'd2);
    drive(3'd5, 8'h00, 3'd0, 8'h00, 1'b0);
    chk("ret1_uaddr", uaddr, 8'h81);
    tick();
    chk("ret1_upc", upc, 8'h81);
    chk("ret1_sp", sp, 3'd1);
    tick();
    chk("ret2_upc", upc, 8'h21);
    chk("ret2_sp", sp, 3'd0);
    chk("ret2_err", stk_err, 1'b0);

    // Overflow: five CALLs from 0x21 to 1,2,3,4,5 push 0x22,2,3,4
    for (int i = 1; i <= 4; i++) begin
      drive(3'd4, i, 3'd0, 8'h00, 1'b0);
      tick();
    end
    chk("fill_sp", sp, 3'd4);
    chk("fill_err", stk_err, 1'b0);
    drive(3'd4, 8'h05, 3'd0, 8'h00, 1'b0);
    tick();
    chk("ovf_upc", upc, 8'h05);
    chk("ovf_sp", sp, 3'd4);
    chk("ovf_err", stk_err, 1'b1);

    // RET, then CALL reusing the freed slot
    drive(3'd5, 8'h00, 3'd0, 8'h00, 1'b0);
    tick();
    chk("pop_a_upc", upc, 8'h04);
    chk("pop_a_sp", sp, 3'd3);
    drive(3'd4, 8'h60, 3'd0, 8'h00, 1'b0);
    tick();
    chk("reuse_upc", upc, 8'h60);
    chk("reuse_sp", sp, 3'd4);
    drive(3'd5, 8'h00, 3'd0, 8'h00, 1'b0);
    tick();
    chk("pop_b_upc", upc, 8'h05);
    tick();
    chk("pop_c_upc", upc, 8'h03);
    tick();
    chk("pop_d_upc", upc, 8'h02);
    tick();
    chk("pop_e_upc", upc, 8'h22);
    chk("pop_e_sp", sp, 3'd0);
    chk("udf_uaddr", uaddr, 8'h00);
    tick();
    chk("udf_upc", upc, 8'h00);
    chk("udf_sp", sp, 3'd0);
    chk("udf_err", stk_err, 1'b1);

    // Stall holds everything
    drive(3'd1, 8'h77, 3'd0, 8'h00, 1'b1);
    chk("stall_uaddr", uaddr, 8'h00);
    tick();
    chk("stall_upc", upc, 8'h00);

    // WAIT with cond low, then stalled, then released
    drive(3'd1, 8'h30, 3'd0, 8'h00, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(3'd7, 8'h00, 3'd5, 8'h00, 1'b0);
      chk("wait_flag", waiting, 1'b1);
      chk("wait_uaddr", uaddr, 8'h30);
      tick();
      chk("wait_upc", upc, 8'h30);
    end
    for (int i = 0; i < 2; i++) begin
      drive(3'd7, 8'h00, 3'd5, 8'h00, 1'b1);
      chk("wstall_flag", waiting, 1'b1);
      chk("wstall_uaddr", uaddr, 8'h30);
      tick();
      chk("wstall_upc", upc, 8'h30);
    end
    drive(3'd7, 8'h00, 3'd5, 8'h20, 1'b0);
    chk("wdone_flag", waiting, 1'b0);
    chk("wdone_uaddr", uaddr, 8'h31);
    tick();
    chk("wdone_upc", upc, 8'h31);

    // Address wrap
    drive(3'd1, 8'hFF, 3'd0, 8'h00, 1'b0);
    tick();
    drive(3'd0, 8'h00, 3'd0, 8'h00, 1'b0);
    chk("wrap_uaddr", uaddr, 8'h00);
    tick();
    chk("wrap_upc", upc, 8'h00);

    // Reset in the middle of a stalled WAIT inside a subroutine
    drive(3'd4, 8'h30, 3'd0, 8'h00, 1'b0);
    tick();
    chk("mid_sp", sp, 3'd1);
    drive(3'd7, 8'h00, 3'd5, 8'h00, 1'b0);
    tick();
    drive(3'd7, 8'h00, 3'd5, 8'h00, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_uaddr", uaddr, 8'h00);
    chk("mid_rst_wait", waiting, 1'b0);
    tick();
    chk("mid_rst_upc", upc, 8'h00);
    chk("mid_rst_sp", sp, 3'd0);
    chk("mid_rst_err", stk_err, 1'b0);
    rst_n = 1'b1;
    drive(3'd0, 8'h00, 3'd0, 8'h00, 1'b0);
    chk("post_rst_uaddr", uaddr, 8'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
